alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Single-cycle integer execute unit of the out-of-order RV32I(C) core. Accepts one ready op per
//  cycle from the reservation station, computes the result, resolves branches/jumps, and drives
//  the common data bus (CDB) to the ROB, RS, LSB and RF one cycle later. No stall or back-pressure.
// PARAMETERS
//  DAT_W    32  data/address width
//  OP_W     6   width of internal opcode (codes in shared package)
//  ROB_BIT  4   ROB tag width (16-entry ROB)
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-low
//  en         in   1        ready/enable; low = freeze (no state or output change)
//  rs_en_i    in   1        valid op from RS this cycle
//  rs_op_i    in   OP_W     internal opcode
//  rs_ic_i    in   1        1 = compressed (2-byte) instruction, else 4-byte
//  rs_qd_i    in   ROB_BIT  destination ROB tag
//  rs_vs_i    in   DAT_W    operand rs1 value
//  rs_vt_i    in   DAT_W    operand rs2 value
//  rs_imm_i   in   DAT_W    sign-extended immediate
//  rs_pc_i    in   DAT_W    instruction PC
//  cdb_en_o   out  1        result valid (one-cycle pulse)
//  cdb_q_o    out  ROB_BIT  ROB tag of result
//  cdb_v_o    out  DAT_W    result value
//  cdb_cbr_o  out  1        1 = control transfer taken
//  cdb_cbt_o  out  DAT_W    resolved next PC
// BEHAVIOUR
//  - Reset (rst==0 at edge): all outputs 0. Reset dominates en.
//  - en==0: all outputs hold previous values; inputs ignored.
//  - en==1, rs_en_i==0: cdb_en_o<=0; other outputs don't-care (hold).
//  - en==1, rs_en_i==1: latency exactly 1 cycle; cdb_en_o<=1, cdb_q_o<=rs_qd_i, and v/cbr/cbt per op.
//    Back-to-back ops every cycle produce back-to-back CDB pulses; no internal queue.
//  - len = rs_ic_i ? 2 : 4; fall = pc+len. All arithmetic mod 2^32.
//  - LUI: v=imm. AUIPC: v=pc+imm. cbr=0, cbt=fall for all non-control ops.
//  - JAL: v=fall, cbr=1, cbt=pc+imm. JALR: v=fall, cbr=1, cbt=(vs+imm)&~1.
//  - BEQ/BNE/BLT/BGE (signed)/BLTU/BGEU (unsigned) on vs,vt: v=0; cbr=cond; cbt=cond?pc+imm:fall.
//  - R-type uses b=vt, I-type uses b=imm: ADD, SUB (R only), AND, OR, XOR,
//    SLT (signed, 1/0), SLTU (unsigned, 1/0), SLL/SRL/SRA shift vs by b[4:0] (SRA arithmetic).
//  - NOP, load/store or undefined codes: still broadcast, v=0, cbr=0, cbt=fall.
//  - Writes to x0 are not filtered here (RF ignores rd=0).
//  - No flush input: results of squashed ops are still broadcast; consumers discard them on br_flag.
// STRUCTURE
//  - Shared package: DAT_W/OP_W/ROB_BIT constants and opcode codes:
//    0 NOP,1 LUI,2 AUIPC,3 JAL,4 JALR,5-10 BEQ BNE BLT BGE BLTU BGEU,11-15 LB LH LW LBU LHU,
//    16-18 SB SH SW,19-27 ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI,
//    28-37 ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//  - One combinational sub-module alu_compute (op,vs,vt,imm,pc,ic -> v,cbr,cbt) plus output register.
// TESTING
//  - rst low 2 cycles, en=1 -> all outputs 0; rs_en_i=0 thereafter -> cdb_en_o stays 0.
//  - ADD vs=7,vt=0xFFFFFFFE,qd=3 -> next cycle cdb_en=1,q=3,v=5,cbr=0,cbt=pc+4.
//  - SRAI vs=0x80000000,imm=4 -> v=0xF8000000; SLTU vs=1,vt=0xFFFFFFFF -> v=1; SLT same -> v=0.
//  - BLT pc=0x100,vs=-1,vt=0,imm=0x20 -> cbr=1,cbt=0x120; BGEU same operands -> cbr=1? no: 0xFFFFFFFF>=0 -> cbr=1,cbt=0x120; BEQ vs=1,vt=2,ic=1 -> cbr=0,cbt=0x102.
//  - JALR pc=0x40,ic=1,vs=0x1001,imm=2 -> v=0x42,cbr=1,cbt=0x1002; JAL pc=0x40,imm=-8 -> v=0x44,cbt=0x38.
//  - Issue op with en=0 -> outputs unchanged; back-to-back ops 3 cycles -> 3 consecutive CDB pulses, correct tags.

Source files
------------

// File: rtl/alu_exec_unit_pkg.sv
// Shared constants, opcode encoding and helpers for the integer execute unit.
package alu_exec_unit_pkg;

    localparam int DAT_W   = 32;
    localparam int OP_W    = 6;
    localparam int ROB_BIT = 4;

    typedef enum logic [OP_W-1:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_LB    = 6'd11,
        OP_LH    = 6'd12,
        OP_LW    = 6'd13,
        OP_LBU   = 6'd14,
        OP_LHU   = 6'd15,
        OP_SB    = 6'd16,
        OP_SH    = 6'd17,
        OP_SW    = 6'd18,
        OP_ADDI  = 6'd19,
        OP_SLTI  = 6'd20,
        OP_SLTIU = 6'd21,
        OP_XORI  = 6'd22,
        OP_ORI   = 6'd23,
        OP_ANDI  = 6'd24,
        OP_SLLI  = 6'd25,
        OP_SRLI  = 6'd26,
        OP_SRAI  = 6'd27,
        OP_ADD   = 6'd28,
        OP_SUB   = 6'd29,
        OP_SLL   = 6'd30,
        OP_SLT   = 6'd31,
        OP_SLTU  = 6'd32,
        OP_XOR   = 6'd33,
        OP_SRL   = 6'd34,
        OP_SRA   = 6'd35,
        OP_OR    = 6'd36,
        OP_AND   = 6'd37
    } alu_op_e;

    typedef struct packed {
        logic [DAT_W-1:0] v;
        logic             cbr;
        logic [DAT_W-1:0] cbt;
    } alu_result_t;

    // Conditional-branch outcome; non-branch opcodes never report taken.
    function automatic logic branch_cond(input logic [OP_W-1:0]  op,
                                         input logic [DAT_W-1:0] a,
                                         input logic [DAT_W-1:0] b);
        logic taken;
        case (op)
            OP_BEQ:  taken = (a == b);
            OP_BNE:  taken = (a != b);
            OP_BLT:  taken = ($signed(a) <  $signed(b));
            OP_BGE:  taken = ($signed(a) >= $signed(b));
            OP_BLTU: taken = (a <  b);
            OP_BGEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/alu_exec_unit_compute.sv
// Combinational datapath: result value, taken flag and resolved next PC for one op.
import alu_exec_unit_pkg::*;

module alu_compute (
    input  logic [OP_W-1:0]  op,
    input  logic [DAT_W-1:0] vs,
    input  logic [DAT_W-1:0] vt,
    input  logic [DAT_W-1:0] imm,
    input  logic [DAT_W-1:0] pc,
    input  logic             ic,
    output logic [DAT_W-1:0] v,
    output logic             cbr,
    output logic [DAT_W-1:0] cbt
);

    logic [DAT_W-1:0] len_s;
    logic [DAT_W-1:0] fall_s;
    logic [DAT_W-1:0] target_s;
    logic [DAT_W-1:0] jalr_sum_s;
    logic [DAT_W-1:0] b_s;
    logic             taken_s;

    assign len_s      = ic ? 32'd2 : 32'd4;
    assign fall_s     = pc + len_s;
    assign target_s   = pc + imm;
    assign jalr_sum_s = vs + imm;
    assign taken_s    = branch_cond(op, vs, vt);

    // Second ALU operand: register for R-type codes, immediate for everything else.
    always_comb begin
        b_s = imm;
        if (op >= OP_ADD) begin
            b_s = vt;
        end else begin
            b_s = imm;
        end
    end

    // Per-opcode result selection; unlisted codes broadcast zero with fall-through PC.
    always_comb begin
        v   = {DAT_W{1'b0}};
        cbr = 1'b0;
        cbt = fall_s;
        case (op)
            OP_LUI:   v = imm;
            OP_AUIPC: v = target_s;
            OP_JAL: begin
                v   = fall_s;
                cbr = 1'b1;
                cbt = target_s;
            end
            OP_JALR: begin
                v   = fall_s;
                cbr = 1'b1;
                cbt = {jalr_sum_s[DAT_W-1:1], 1'b0};
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                cbr = taken_s;
                cbt = taken_s ? target_s : fall_s;
            end
            OP_ADDI, OP_ADD:  v = vs + b_s;
            OP_SUB:           v = vs - b_s;
            OP_ANDI, OP_AND:  v = vs & b_s;
            OP_ORI,  OP_OR:   v = vs | b_s;
            OP_XORI, OP_XOR:  v = vs ^ b_s;
            OP_SLTI, OP_SLT:  v = {{(DAT_W-1){1'b0}}, ($signed(vs) < $signed(b_s))};
            OP_SLTIU, OP_SLTU: v = {{(DAT_W-1){1'b0}}, (vs < b_s)};
            OP_SLLI, OP_SLL:  v = vs << b_s[4:0];
            OP_SRLI, OP_SRL:  v = vs >> b_s[4:0];
            OP_SRAI, OP_SRA:  v = $unsigned($signed(vs) >>> b_s[4:0]);
            default: begin
                v   = {DAT_W{1'b0}};
                cbr = 1'b0;
                cbt = fall_s;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Single-cycle integer execute unit; registers the computed result onto the CDB.
import alu_exec_unit_pkg::*;

module alu_exec_unit (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               rs_en_i,
    input  logic [OP_W-1:0]    rs_op_i,
    input  logic               rs_ic_i,
    input  logic [ROB_BIT-1:0] rs_qd_i,
    input  logic [DAT_W-1:0]   rs_vs_i,
    input  logic [DAT_W-1:0]   rs_vt_i,
    input  logic [DAT_W-1:0]   rs_imm_i,
    input  logic [DAT_W-1:0]   rs_pc_i,
    output logic               cdb_en_o,
    output logic [ROB_BIT-1:0] cdb_q_o,
    output logic [DAT_W-1:0]   cdb_v_o,
    output logic               cdb_cbr_o,
    output logic [DAT_W-1:0]   cdb_cbt_o
);

    alu_result_t        res_s;
    logic               cdb_en_r;
    logic [ROB_BIT-1:0] cdb_q_r;
    alu_result_t        cdb_res_r;

    alu_compute u_compute (
        .op  (rs_op_i),
        .vs  (rs_vs_i),
        .vt  (rs_vt_i),
        .imm (rs_imm_i),
        .pc  (rs_pc_i),
        .ic  (rs_ic_i),
        .v   (res_s.v),
        .cbr (res_s.cbr),
        .cbt (res_s.cbt)
    );

    // CDB output register: reset clears, en low freezes, idle cycles only drop the valid pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cdb_en_r  <= 1'b0;
            cdb_q_r   <= {ROB_BIT{1'b0}};
            cdb_res_r <= '0;
        end else if (en) begin
            cdb_en_r <= rs_en_i;
            if (rs_en_i) begin
                cdb_q_r   <= rs_qd_i;
                cdb_res_r <= res_s;
            end
        end
    end

    assign cdb_en_o  = cdb_en_r;
    assign cdb_q_o   = cdb_q_r;
    assign cdb_v_o   = cdb_res_r.v;
    assign cdb_cbr_o = cdb_res_r.cbr;
    assign cdb_cbt_o = cdb_res_r.cbt;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected CDB beats queued at issue, compared on output.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rs_en_i;
    logic [5:0]  rs_op_i;
    logic        rs_ic_i;
    logic [3:0]  rs_qd_i;
    logic [31:0] rs_vs_i;
    logic [31:0] rs_vt_i;
    logic [31:0] rs_imm_i;
    logic [31:0] rs_pc_i;
    logic        cdb_en_o;
    logic [3:0]  cdb_q_o;
    logic [31:0] cdb_v_o;
    logic        cdb_cbr_o;
    logic [31:0] cdb_cbt_o;

    typedef struct packed {
        logic [3:0]  q;
        logic [31:0] v;
        logic        cbr;
        logic [31:0] cbt;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   pushed = 0;
    int   pulses = 0;
    logic [3:0] tag_r = 4'd0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rs_en_i   (rs_en_i),
        .rs_op_i   (rs_op_i),
        .rs_ic_i   (rs_ic_i),
        .rs_qd_i   (rs_qd_i),
        .rs_vs_i   (rs_vs_i),
        .rs_vt_i   (rs_vt_i),
        .rs_imm_i  (rs_imm_i),
        .rs_pc_i   (rs_pc_i),
        .cdb_en_o  (cdb_en_o),
        .cdb_q_o   (cdb_q_o),
        .cdb_v_o   (cdb_v_o),
        .cdb_cbr_o (cdb_cbr_o),
        .cdb_cbt_o (cdb_cbt_o)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Drive one op right after a rising edge and queue its expected CDB beat.
    task automatic issue(input logic [5:0] op, input logic ic, input logic [31:0] vs,
                         input logic [31:0] vt, input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] ev, input logic ecbr, input logic [31:0] ecbt);
        exp_t e;
        @(posedge clk);
        #1;
        rs_en_i  = 1'b1;
        rs_op_i  = op;
        rs_ic_i  = ic;
        rs_qd_i  = tag_r;
        rs_vs_i  = vs;
        rs_vt_i  = vt;
        rs_imm_i = imm;
        rs_pc_i  = pc;
        e.q = tag_r; e.v = ev; e.cbr = ecbr; e.cbt = ecbt;
        sb_q.push_back(e);
        pushed++;
        tag_r = tag_r + 4'd1;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        rs_en_i = 1'b0;
    endtask

    // Monitor on the falling edge: every CDB pulse must match the oldest queued beat.
    always @(negedge clk) begin
        if (cdb_en_o === 1'b1) begin
            exp_t e;
            pulses++;
            if (sb_q.size() == 0) begin
                check_value("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check_value("cdb_q",   {28'd0, cdb_q_o}, {28'd0, e.q});
                check_value("cdb_v",   cdb_v_o, e.v);
                check_value("cdb_cbr", {31'd0, cdb_cbr_o}, {31'd0, e.cbr});
                check_value("cdb_cbt", cdb_cbt_o, e.cbt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        int          waited;
        rst = 1'b0; en = 1'b1; rs_en_i = 1'b0; rs_op_i = 6'd0; rs_ic_i = 1'b0;
        rs_qd_i = 4'd0; rs_vs_i = 32'd0; rs_vt_i = 32'd0; rs_imm_i = 32'd0; rs_pc_i = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("rst_en",  {31'd0, cdb_en_o}, 32'd0);
        check_value("rst_q",   {28'd0, cdb_q_o}, 32'd0);
        check_value("rst_v",   cdb_v_o, 32'd0);
        check_value("rst_cbr", {31'd0, cdb_cbr_o}, 32'd0);
        check_value("rst_cbt", cdb_cbt_o, 32'd0);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_value("idle_en", {31'd0, cdb_en_o}, 32'd0);

        tag_r = 4'd3;
        issue(6'd28, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'h200, 32'd5, 1'b0, 32'h204);
        issue(6'd27, 1'b0, 32'h8000_0000, 32'd0, 32'd4, 32'h204, 32'hF800_0000, 1'b0, 32'h208);
        issue(6'd32, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h208, 32'd1, 1'b0, 32'h20C);
        issue(6'd31, 1'b0, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'h20C, 32'd0, 1'b0, 32'h210);
        issue(6'd7,  1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 32'd0, 1'b1, 32'h120);
        issue(6'd10, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'h20, 32'h100, 32'd0, 1'b1, 32'h120);
        issue(6'd5,  1'b1, 32'd1, 32'd2, 32'h20, 32'h100, 32'd0, 1'b0, 32'h102);
        issue(6'd4,  1'b1, 32'h1001, 32'd0, 32'd2, 32'h40, 32'h42, 1'b1, 32'h1002);
        issue(6'd3,  1'b0, 32'd0, 32'd0, 32'hFFFF_FFF8, 32'h40, 32'h44, 1'b1, 32'h38);
        idle();
        issue(6'd1,  1'b0, 32'd9, 32'd9, 32'h1234_5000, 32'h10, 32'h1234_5000, 1'b0, 32'h14);
        issue(6'd2,  1'b1, 32'd0, 32'd0, 32'h2000, 32'h1000, 32'h3000, 1'b0, 32'h1002);
        issue(6'd29, 1'b0, 32'd5, 32'd7, 32'd99, 32'h0, 32'hFFFF_FFFE, 1'b0, 32'h4);
        issue(6'd30, 1'b0, 32'd1, 32'h21, 32'd0, 32'h0, 32'd2, 1'b0, 32'h4);
        issue(6'd34, 1'b0, 32'h8000_0000, 32'd31, 32'd0, 32'h0, 32'd1, 1'b0, 32'h4);
        issue(6'd35, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 32'h0, 32'hC000_0000, 1'b0, 32'h4);
        issue(6'd33, 1'b0, 32'hF0, 32'hFF, 32'd0, 32'h0, 32'h0F, 1'b0, 32'h4);
        issue(6'd36, 1'b0, 32'hF0, 32'h0F, 32'd0, 32'h0, 32'hFF, 1'b0, 32'h4);
        issue(6'd37, 1'b0, 32'hF0, 32'h3C, 32'd0, 32'h0, 32'h30, 1'b0, 32'h4);
        issue(6'd19, 1'b0, 32'd1, 32'd5, 32'hFFFF_FFFF, 32'h0, 32'd0, 1'b0, 32'h4);
        issue(6'd20, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'h0, 32'd1, 1'b0, 32'h4);
        issue(6'd21, 1'b0, 32'hFFFF_FFFE, 32'd0, 32'd1, 32'h0, 32'd0, 1'b0, 32'h4);
        issue(6'd22, 1'b0, 32'hF0, 32'd0, 32'hFF, 32'h0, 32'h0F, 1'b0, 32'h4);
        issue(6'd23, 1'b0, 32'hF0, 32'd0, 32'h0F, 32'h0, 32'hFF, 1'b0, 32'h4);
        issue(6'd24, 1'b0, 32'hF0, 32'd0, 32'h3C, 32'h0, 32'h30, 1'b0, 32'h4);
        issue(6'd25, 1'b0, 32'd3, 32'd0, 32'd4, 32'h0, 32'h30, 1'b0, 32'h4);
        issue(6'd26, 1'b0, 32'h80, 32'd0, 32'd4, 32'h0, 32'd8, 1'b0, 32'h4);
        issue(6'd6,  1'b0, 32'd1, 32'd2, 32'h10, 32'h300, 32'd0, 1'b1, 32'h310);
        issue(6'd8,  1'b0, 32'hFFFF_FFFF, 32'd0, 32'h10, 32'h300, 32'd0, 1'b0, 32'h304);
        issue(6'd9,  1'b0, 32'hFFFF_FFFF, 32'd0, 32'h10, 32'h300, 32'd0, 1'b0, 32'h304);
        issue(6'd13, 1'b0, 32'h55, 32'h66, 32'h8, 32'h400, 32'd0, 1'b0, 32'h404);
        issue(6'd50, 1'b1, 32'h55, 32'h66, 32'h8, 32'h400, 32'd0, 1'b0, 32'h402);
        issue(6'd0,  1'b0, 32'h55, 32'h66, 32'h8, 32'hFFFF_FFFC, 32'd0, 1'b0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            a = $urandom();
            b = $urandom();
            if (i[0]) issue(6'd33, 1'b0, a, b, 32'd0, 32'h500, a ^ b, 1'b0, 32'h504);
            else      issue(6'd28, 1'b0, a, b, 32'd0, 32'h500, a + b, 1'b0, 32'h504);
        end
        idle();

        // Freeze: with en low a new op must not disturb the held outputs.
        issue(6'd1, 1'b0, 32'd0, 32'd0, 32'hCAFE_0000, 32'h80, 32'hCAFE_0000, 1'b0, 32'h84);
        idle();
        @(posedge clk);
        #1;
        en = 1'b0; rs_en_i = 1'b1; rs_op_i = 6'd3; rs_qd_i = 4'hE;
        rs_imm_i = 32'h0000_0100; rs_pc_i = 32'h9000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_value("hold_en",  {31'd0, cdb_en_o}, 32'd0);
        check_value("hold_q",   {28'd0, cdb_q_o}, {28'd0, tag_r - 4'd1});
        check_value("hold_v",   cdb_v_o, 32'hCAFE_0000);
        check_value("hold_cbr", {31'd0, cdb_cbr_o}, 32'd0);
        check_value("hold_cbt", cdb_cbt_o, 32'h84);
        #1;
        en = 1'b1; rs_en_i = 1'b0;

        waited = 0;
        while (sb_q.size() != 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        check_value("sb_drained", sb_q.size(), 32'd0);
        check_value("pulse_count", pulses, pushed);

        // Reset must win even while en is low.
        @(posedge clk);
        #1;
        en = 1'b0; rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_value("rst2_v",   cdb_v_o, 32'd0);
        check_value("rst2_q",   {28'd0, cdb_q_o}, 32'd0);
        check_value("rst2_cbt", cdb_cbt_o, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
